// File: rtl/decode_pipe.sv
// MIPS decode stage with ID/EX register; mul decode and occupancy built only with DECODE_PIPE_MUL_EN.
// Latency: 1 cycle from accept to out_valid; 1 instr/cycle absent load-use or mul stalls.
// Backpressure: out_valid & !out_ready holds the register and drops in_ready; flush always accepts.
module decode_pipe #(
    parameter int PC_W    = 32,
    parameter int ALUOP_W = 5,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               out_branch,
    output logic               out_j0,
    output logic               out_j1,
    output logic               out_mem_en,
    output logic               out_mem_wen,
    output logic               out_byte_en,
    output logic               out_reg_wen,
    output logic [4:0]         out_r1,
    output logic [4:0]         out_r2,
    output logic [4:0]         out_w,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_shift,
    output logic               out_aluimm,
    output logic               out_mul_en,
    output logic               out_illegal
);

    typedef struct packed {
        logic               branch;
        logic               j0;
        logic               j1;
        logic               mem_en;
        logic               mem_wen;
        logic               byte_en;
        logic               reg_wen;
        logic [4:0]         r1;
        logic [4:0]         r2;
        logic [4:0]         w;
        logic [ALUOP_W-1:0] aluop;
        logic               shift;
        logic               aluimm;
        logic               mul_en;
        logic               illegal;
    } ctl_t;

    localparam logic [ALUOP_W-1:0] A_ADD   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] A_ADDU  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] A_AND   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] A_OR    = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] A_XOR   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] A_SLT   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] A_SLTU  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] A_SLL   = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] A_SRL   = ALUOP_W'(12);
    localparam logic [ALUOP_W-1:0] A_SRA   = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] A_PASSA = ALUOP_W'(14);
    localparam logic [ALUOP_W-1:0] A_LUI   = ALUOP_W'(16);
    localparam logic [ALUOP_W-1:0] A_EQ    = ALUOP_W'(17);
    localparam logic [ALUOP_W-1:0] A_NE    = ALUOP_W'(18);
    localparam logic [ALUOP_W-1:0] A_GTZ   = ALUOP_W'(19);

    if (ALUOP_W < 5) begin : g_bad_aluop_w
        $error("decode_pipe: ALUOP_W must be at least 5");
    end
    if (MUL_LAT < 1) begin : g_bad_mul_lat
        $error("decode_pipe: MUL_LAT must be at least 1");
    end

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    ctl_t       w_dec;
    ctl_t       w_raw;
    logic       w_hazard;
    logic       w_mul_idle;
    logic       w_accept;

    ctl_t            r_ctl;
    logic            r_valid;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc;

    assign w_op = in_instr[31:26];
    assign w_rs = in_instr[25:21];
    assign w_rt = in_instr[20:16];
    assign w_rd = in_instr[15:11];
    assign w_fn = in_instr[5:0];

    always_comb begin
        w_raw = '0;
        case (w_op)
            6'b000000: begin
                w_raw.r1      = w_rs;
                w_raw.r2      = w_rt;
                w_raw.w       = w_rd;
                w_raw.reg_wen = 1'b1;
                casez (w_fn)
                    6'b100???: w_raw.aluop = ALUOP_W'(w_fn[2:0]) + ALUOP_W'(1);
                    6'b101010: w_raw.aluop = A_SLT;
                    6'b101011: w_raw.aluop = A_SLTU;
                    6'b000000: begin w_raw.aluop = A_SLL; w_raw.shift = 1'b1; end
                    6'b000010: begin w_raw.aluop = A_SRL; w_raw.shift = 1'b1; end
                    6'b000011: begin w_raw.aluop = A_SRA; w_raw.shift = 1'b1; end
                    6'b000100: w_raw.aluop = A_SLL;
                    6'b000110: w_raw.aluop = A_SRL;
                    6'b000111: w_raw.aluop = A_SRA;
                    6'b001000: begin
                        w_raw.branch  = 1'b1;
                        w_raw.aluop   = A_PASSA;
                        w_raw.reg_wen = 1'b0;
                        w_raw.w       = 5'd0;
                        w_raw.r2      = 5'd0;
                    end
                    default:   w_raw.illegal = 1'b1;
                endcase
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                w_raw.r1      = (w_op == 6'b001111) ? 5'd0 : w_rs;
                w_raw.w       = w_rt;
                w_raw.reg_wen = 1'b1;
                w_raw.aluimm  = 1'b1;
                case (w_op[2:0])
                    3'b000:  w_raw.aluop = A_ADD;
                    3'b001:  w_raw.aluop = A_ADDU;
                    3'b010:  w_raw.aluop = A_SLT;
                    3'b011:  w_raw.aluop = A_SLTU;
                    3'b100:  w_raw.aluop = A_AND;
                    3'b101:  w_raw.aluop = A_OR;
                    3'b110:  w_raw.aluop = A_XOR;
                    default: w_raw.aluop = A_LUI;
                endcase
            end
            6'b100011, 6'b100000: begin
                w_raw.r1      = w_rs;
                w_raw.w       = w_rt;
                w_raw.reg_wen = 1'b1;
                w_raw.aluimm  = 1'b1;
                w_raw.aluop   = A_ADD;
                w_raw.mem_en  = 1'b1;
                w_raw.byte_en = (w_op == 6'b100000);
            end
            6'b101011, 6'b101000: begin
                w_raw.r1      = w_rs;
                w_raw.r2      = w_rt;
                w_raw.aluimm  = 1'b1;
                w_raw.aluop   = A_ADD;
                w_raw.mem_en  = 1'b1;
                w_raw.mem_wen = 1'b1;
                w_raw.byte_en = (w_op == 6'b101000);
            end
            6'b000100, 6'b000101, 6'b000111: begin
                w_raw.branch = 1'b1;
                w_raw.j0     = 1'b1;
                w_raw.r1     = w_rs;
                w_raw.r2     = (w_op == 6'b000111) ? 5'd0 : w_rt;
                w_raw.aluop  = (w_op == 6'b000100) ? A_EQ :
                               (w_op == 6'b000101) ? A_NE : A_GTZ;
            end
            6'b000010, 6'b000011: begin
                w_raw.branch  = 1'b1;
                w_raw.j0      = 1'b1;
                w_raw.j1      = 1'b1;
                w_raw.reg_wen = (w_op == 6'b000011);
                w_raw.w       = (w_op == 6'b000011) ? 5'd31 : 5'd0;
            end
`ifdef DECODE_PIPE_MUL_EN
            6'b011100: begin
                w_raw.r1      = w_rs;
                w_raw.r2      = w_rt;
                w_raw.w       = w_rd;
                w_raw.reg_wen = 1'b1;
                w_raw.mul_en  = 1'b1;
            end
`endif
            default: w_raw.illegal = 1'b1;
        endcase
    end

    // An illegal word keeps only its flag so nothing downstream acts on stray fields.
    always_comb begin
        w_dec = w_raw;
        if (w_raw.illegal) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end
    end

    assign w_hazard = r_valid && r_ctl.mem_en && !r_ctl.mem_wen && (r_ctl.w != 5'd0) &&
                      (((w_dec.r1 != 5'd0) && (w_dec.r1 == r_ctl.w)) ||
                       ((w_dec.r2 != 5'd0) && (w_dec.r2 == r_ctl.w)));

    assign in_ready = flush | ((!r_valid | out_ready) & !w_hazard & w_mul_idle);
    assign w_accept = in_valid & in_ready & !flush;

`ifdef DECODE_PIPE_MUL_EN
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    logic [CNT_W-1:0] r_mul_cnt;

    assign w_mul_idle = (r_mul_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_mul_cnt <= '0;
        end else if (w_accept && w_dec.mul_en) begin
            r_mul_cnt <= CNT_W'(MUL_LAT - 1);
        end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - CNT_W'(1);
        end
    end
`else
    assign w_mul_idle = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctl   <= w_dec;
            r_instr <= in_instr;
            r_pc    <= in_pc;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_instr   = r_instr;
    assign out_pc      = r_pc;
    assign out_branch  = r_ctl.branch;
    assign out_j0      = r_ctl.j0;
    assign out_j1      = r_ctl.j1;
    assign out_mem_en  = r_ctl.mem_en;
    assign out_mem_wen = r_ctl.mem_wen;
    assign out_byte_en = r_ctl.byte_en;
    assign out_reg_wen = r_ctl.reg_wen;
    assign out_r1      = r_ctl.r1;
    assign out_r2      = r_ctl.r2;
    assign out_w       = r_ctl.w;
    assign out_aluop   = r_ctl.aluop;
    assign out_shift   = r_ctl.shift;
    assign out_aluimm  = r_ctl.aluimm;
    assign out_mul_en  = r_ctl.mul_en;
    assign out_illegal = r_ctl.illegal;

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered MIPS instruction-decode stage that turns a fetched 32-bit instruction into the ALU, memory, register-file and branch control bundle, then holds it in an ID/EX pipeline register. It sits between fetch and execute and adds what a purely combinational decoder lacks:
- valid/ready handshakes on both sides
- load-use hazard bubbles
- multi-cycle multiply occupancy
- branch flush
- illegal-instruction flagging

## Interface
Parameters:
- PC_W, 32, width of the program counter carried with the instruction
- ALUOP_W, 5, ALU opcode width (must be ≥5)
- MUL_LAT, 3, multiply latency in cycles (≥1); the stage stays busy for MUL_LAT-1 cycles after issuing a mul

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle (combinational)
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- flush  in  1  branch resolved taken; kill stage contents
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  execute consumes the ID/EX register this cycle
- out_instr, out_pc  out  32, PC_W  passthrough of the accepted instruction and address
- out_branch, out_j0, out_j1  out  1 each  branch, ALU-target, absolute-jump controls
- out_mem_en, out_mem_wen, out_byte_en  out  1 each  data memory controls
- out_reg_wen  out  1  register-file write enable
- out_r1, out_r2, out_w  out  5 each  read and write register indices (0 when unused)
- out_aluop  out  ALUOP_W  ALU operation
- out_shift, out_aluimm, out_mul_en  out  1 each  shamt shift, immediate B operand, multiplier select
- out_illegal  out  1  undecodable opcode/func

## Operation
ALUop codes:
- 0 none, 1 add, 2 addu, 3 sub, 4 subu, 5 and, 6 or, 7 xor, 8 nor, 9 slt, 10 sltu
- 11 sll, 12 srl, 13 sra, 14 passA, 16 lui, 17 eq, 18 ne, 19 gtz

R-type (op 000000): r1=rs, r2=rt, w=rd, reg_wen=1.
- Funcs 100000–100111 map to 1–8; 101010→9; 101011→10.
- 000000/000010/000011 → 11/12/13 with shift=1.
- 000100/000110/000111 → 11/12/13 with shift=0.
- 001000 (jr) → branch=1, j0=0, j1=0, ALUop 14, reg_wen=0, w=0, r2=0.

I-type: r1=rs, w=rt, reg_wen=1, aluimm=1.
- addi 1, addiu 2, andi 5, ori 6, xori 7, slti 9, sltiu 10.
- lui 16 with r1=0.

Loads and stores:
- lw 100011 / lb 100000: ALUop 1, mem_en=1; lb sets byte_en.
- sw 101011 / sb 101000: ALUop 1, mem_en=1, mem_wen=1, reg_wen=0, r2=rt; sb sets byte_en.

Branches and jumps:
- beq 000100 (17), bne 000101 (18): branch=1, j0=1, r1=rs, r2=rt.
- bgtz 000111 (19): branch=1, j0=1, r1=rs, r2=0.
- j 000010: branch=1, j0=1, j1=1.
- jal 000011: same as j plus reg_wen=1, w=31.

mul (op 011100): r1=rs, r2=rt, w=rd, reg_wen=1, mul_en=1.

Any other encoding: illegal=1 and every other control 0. An illegal instruction still flows down the pipe.

Hazards and occupancy:
- **Load-use hazard:** out_valid, out_mem_en, !out_mem_wen, out_w≠0, and out_w equal to the current decoded nonzero r1 or r2.
- **Multiply occupancy:** counter mul_cnt, loaded with MUL_LAT-1 when a mul is accepted, then decrements by 1 every cycle while nonzero.
- **Handshake:** in_ready = flush | ((!out_valid | out_ready) & !hazard & mul_cnt==0).

Register update priority:
1. rst: clear everything.
2. flush: out_valid←0, mul_cnt←0; the input is accepted and discarded.
3. in_valid & in_ready: load the decoded bundle, out_valid←1.
4. out_ready (nothing accepted): out_valid←0, a bubble.
5. Otherwise: hold.

## Timing
- Decode-to-output latency is 1 cycle; throughput is 1 instruction/cycle with no hazards.
- Reset: out_valid=0, every out_* control and index=0, out_instr=0, out_pc=0, mul_cnt=0. in_ready follows the handshake expression; with the registers cleared and flush low it evaluates to 1.
- A load-use hazard inserts exactly 1 bubble (the output is invalid for 1 cycle); the dependent instruction issues the following cycle.
- A mul blocks acceptance for MUL_LAT-1 cycles after issue. MUL_LAT=1 means no stall.
- Back-pressure (out_valid & !out_ready) holds every output stable. The hazard check is evaluated against the held register.
- flush concurrent with out_ready, a hazard, or a nonzero mul_cnt: flush wins.
- rst concurrent with flush: rst wins.

## Configuration
- `DECODE_PIPE_MUL_EN` defined: mul decodes as above and the mul_cnt occupancy logic is built.
- Undefined: op 011100 decodes as illegal, out_mul_en is tied to 0, mul_cnt logic is removed, and MUL_LAT is ignored.

## Test plan
- **Reset:** rst for 2 cycles, then release → out_valid=0, all controls 0, in_ready=1.
- **Basic decode:** addi 0x2008_0005 followed by add 0x0109_5020 with out_ready=1 → cycle 1: aluop=1, aluimm=1, w=8. Cycle 2: aluop=1, r1=8, r2=9, w=10. No stalls.
- **Load-use:** lw 0x8D09_0000 then add 0x0129_5020 → in_ready=0 for 1 cycle, then 1 bubble, then the add issues.
- **Multiply:** mul 0x7109_5002 with MUL_LAT=3 → in_ready low for 2 cycles after issue. Without the macro, out_illegal=1 and no stall.
- **Flush:** flush during a mul stall → out_valid=0 and mul_cnt=0 next cycle, and in_ready=1 immediately.
- **Back-pressure and illegal:** opcode 0x3F, then out_ready held 0 for 3 cycles → out_illegal=1 held with out_valid=1 and outputs stable, and in_ready=0 until out_ready rises.
